prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a byte stream into instruction words,
// writes them to instruction memory, then releases the CPU from reset.
module prog_loader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned HCW    = $clog2(HOLD_CYC + 1);
  localparam logic [ADDR_W:0] DEPTH_WC = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;

  logic [DATA_W-1:0] placed;
  logic              accept;
  logic              word_full;
  logic              overflow;
  logic              enter_load;

  assign in_ready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign accept    = in_valid && in_ready;
  assign word_full = (byte_cnt_q == BCW'(NBYTES - 1));
  assign overflow  = (word_count_q == DEPTH_WC);

  // Partial word with the incoming byte dropped into its big-endian lane.
  always_comb begin
    placed = asm_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (byte_cnt_q == BCW'(i)) begin
        placed[DATA_W-1-8*i -: 8] = in_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    hold_cnt_d   = hold_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;
    word_count_d = word_count_q;
    enter_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (word_full || in_last) begin
            asm_d      = '0;
            byte_cnt_d = '0;
            // A completed word with no room left is dropped, not written.
            if (overflow) begin
              err_d   = 1'b1;
              state_d = in_last ? S_IDLE : S_DRAIN;
            end else begin
              mem_we_d     = 1'b1;
              mem_addr_d   = word_count_q[ADDR_W-1:0];
              mem_wdata_d  = placed;
              word_count_d = word_count_q + (ADDR_W + 1)'(1);
              if (in_last) begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
              end
            end
          end else begin
            asm_d      = placed;
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HCW'(HOLD_CYC - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      S_RUN: begin
        if (start) begin
          enter_load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_load) begin
      state_d      = S_LOAD;
      word_count_d = '0;
      byte_cnt_d   = '0;
      asm_d        = '0;
      err_d        = 1'b0;
    end

    // CPU reset and done track the state being entered so they stay registered.
    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      hold_cnt_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      hold_cnt_q   <= hold_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = word_count_q;

endmodule
